vselect_stream: RTL and testbench

Parametrised lane-select and vector-serialise unit for the vector lane datapath. It accepts a K-lane vector together with a request. It then returns either one selected lane (single mode) or a run of consecutive lanes, one per cycle (stream mode), on a valid/ready output port. The vector is snapshotted on request acceptance, so the producer may change `data_in` immediately afterwards. It sits between the vector register file and scalar consumers such as the scalar unit and the store path.

---
 rtl/vselect_stream.sv | 108 ++++++++++
 tb/tb_vselect_stream.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vselect_stream.sv
// vselect_stream: snapshots a K-lane vector and returns one lane (single) or a wrapping run of lanes (stream).
// Stream mode, the STREAM state and the remaining counter exist only when VSELECT_STREAM_EN is defined.
module vselect_stream #(
   parameter int K = 8,
   parameter int W = 32,
   parameter int IDXW = 32,
   localparam int LW = $clog2(K)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [K*W-1:0]  data_in,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_mode,
   input  logic [IDXW-1:0] req_index,
   input  logic [IDXW-1:0] req_count,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    out_data,
   output logic [LW-1:0]   out_lane,
   output logic            out_last,
   output logic            busy
);
   logic [K*W-1:0] snap_q, snap_d;
   logic [LW-1:0] lane_q, lane_d, start_lane;
   logic out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic idle, accept, hs;
   // Out-of-range index falls back to lane 0 (legacy behaviour).
   assign start_lane = (req_index >= IDXW'(K)) ? '0 : req_index[LW-1:0];
`ifdef VSELECT_STREAM_EN
   typedef enum logic {IDLE, STREAM} state_t;
   state_t state_q, state_d;
   logic [IDXW-1:0] rem_q, rem_d, n_eff;
   logic [LW-1:0] next_lane;
   assign idle = state_q == IDLE;
   assign n_eff = (req_count == '0 || req_count > IDXW'(K)) ? IDXW'(K) : req_count;
   assign next_lane = (lane_q == LW'(K-1)) ? '0 : lane_q + LW'(1);
`else
   logic unused_cfg;
   assign idle = 1'b1;
   assign unused_cfg = ^{req_mode, req_count};
`endif
   assign req_ready = idle && (!out_valid_q || out_ready);
   assign accept = req_valid && req_ready;
   assign hs = out_valid_q && out_ready;
   always_comb begin
      snap_d = snap_q;
      lane_d = lane_q;
      out_valid_d = out_valid_q;
      out_last_d = out_last_q;
`ifdef VSELECT_STREAM_EN
      state_d = state_q;
      rem_d = rem_q;
`endif
      if (accept) begin
         snap_d = data_in;
         lane_d = start_lane;
         out_valid_d = 1'b1;
         out_last_d = 1'b1;
`ifdef VSELECT_STREAM_EN
         if (req_mode) begin
            out_last_d = n_eff == IDXW'(1);
            rem_d = n_eff - IDXW'(1);
            state_d = (n_eff > IDXW'(1)) ? STREAM : IDLE;
         end
`endif
      end else if (hs) begin
`ifdef VSELECT_STREAM_EN
         if (!idle && rem_q != '0) begin
            lane_d = next_lane;
            rem_d = rem_q - IDXW'(1);
            out_last_d = rem_q == IDXW'(1);
         end else begin
            out_valid_d = 1'b0;
            state_d = IDLE;
         end
`else
         out_valid_d = 1'b0;
`endif
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_q <= '0;
         lane_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q <= 1'b0;
`ifdef VSELECT_STREAM_EN
         state_q <= IDLE;
         rem_q <= '0;
`endif
      end else begin
         snap_q <= snap_d;
         lane_q <= lane_d;
         out_valid_q <= out_valid_d;
         out_last_q <= out_last_d;
`ifdef VSELECT_STREAM_EN
         state_q <= state_d;
         rem_q <= rem_d;
`endif
      end
   end
   assign out_valid = out_valid_q;
   assign out_last = out_last_q;
   assign out_lane = lane_q;
   assign out_data = snap_q[lane_q*W +: W];
   assign busy = !idle || out_valid_q;
endmodule

// File: tb/tb_vselect_stream.sv
// tb_vselect_stream: random and directed stimulus checked against a queue-of-elements reference model.
module tb_vselect_stream;
   localparam int K = 8, W = 32, IDXW = 32, LW = 3;
   logic clk = 1'b0, reset = 1'b1;
   logic [K*W-1:0] data_in = '0;
   logic req_valid = 1'b0, req_mode = 1'b0, out_ready = 1'b0;
   logic [IDXW-1:0] req_index = '0, req_count = '0;
   logic req_ready, out_valid, out_last, busy;
   logic [W-1:0] out_data;
   logic [LW-1:0] out_lane;
   int vectors = 0, miscompares = 0;
   typedef struct packed {logic [W-1:0] d; logic [LW-1:0] l; logic last;} elem_t;
   typedef logic [W+LW+3:0] view_t;
   elem_t q[$];
   bit multi = 1'b0;

   always #5 clk = ~clk;

   vselect_stream #(.K(K), .W(W), .IDXW(IDXW)) dut (
      .clk(clk), .reset(reset), .data_in(data_in),
      .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
      .req_index(req_index), .req_count(req_count),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_lane(out_lane), .out_last(out_last), .busy(busy)
   );

   // Ready unless elements of a multi-element run are still pending.
   function automatic bit m_ready();
      return q.size() == 0 || (q.size() == 1 && !multi && out_ready === 1'b1);
   endfunction

   function automatic view_t model_view();
      return {m_ready(), q.size() > 0, q.size() > 0, q.size() > 0 ? q[0] : elem_t'(0)};
   endfunction

   function automatic view_t dut_view();
      return {req_ready, out_valid, busy, out_valid ? {out_data, out_lane, out_last} : {(W+LW+1){1'b0}}};
   endfunction

   task automatic rand_data();
      for (int i = 0; i < K; i++) data_in[i*W +: W] = $urandom;
   endtask

   task automatic advance();
      bit hs, acc, mode;
      logic [K*W-1:0] v;
      int start, n;
      hs = q.size() > 0 && out_ready === 1'b1;
      acc = req_valid && m_ready();
      v = data_in;
`ifdef VSELECT_STREAM_EN
      mode = req_mode;
`else
      mode = 1'b0;
`endif
      start = (req_index >= K) ? 0 : int'(req_index);
      n = !mode ? 1 : (req_count == 0 || req_count > K) ? K : int'(req_count);
      @(posedge clk);
      #1;
      if (hs) void'(q.pop_front());
      if (acc) begin
         for (int e = 0; e < n; e++)
            q.push_back('{v[((start + e) % K)*W +: W], LW'((start + e) % K), e == n - 1});
         multi = n > 1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({out_valid, out_data, out_lane, out_last, busy} !== '0) begin
         miscompares++;
         $display("FAIL reset_values: got %h required 0", {out_valid, out_data, out_lane, out_last, busy});
      end
      reset = 1'b0;
      #1;
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: got %b required 1", req_ready);
      end
   endtask

   task automatic test_single();
      for (int i = 0; i < K; i++) data_in[i*W +: W] = 32'h1000 + i;
      out_ready = 1'b1;
      req_mode = 1'b0;
      req_count = '0;
      for (int i = 0; i <= K; i++) begin
         req_valid = 1'b1;
         req_index = (i == K) ? 9 : i;
         #1;
         vectors++;
         if (dut_view() !== model_view()) begin
            miscompares++;
            $display("FAIL single: dut %h model %h", dut_view(), model_view());
         end
         advance();
      end
      req_valid = 1'b0;
      for (int c = 0; c < 8 && q.size() > 0; c++) begin
         #1;
         vectors++;
         if (dut_view() !== model_view()) begin
            miscompares++;
            $display("FAIL single_drain: dut %h model %h", dut_view(), model_view());
         end
         advance();
      end
   endtask

   task automatic test_stream_wrap();
      rand_data();
      out_ready = 1'b1;
      req_valid = 1'b1;
      req_mode = 1'b1;
      req_index = 6;
      req_count = 4;
      for (int c = 0; c < 12; c++) begin
         #1;
         vectors++;
         if (dut_view() !== model_view()) begin
            miscompares++;
            $display("FAIL stream_wrap: dut %h model %h", dut_view(), model_view());
         end
         advance();
         rand_data();
      end
      req_valid = 1'b0;
      for (int c = 0; c < 16 && q.size() > 0; c++) begin
         #1;
         vectors++;
         if (dut_view() !== model_view()) begin
            miscompares++;
            $display("FAIL stream_wrap_drain: dut %h model %h", dut_view(), model_view());
         end
         advance();
      end
   endtask

   task automatic test_count_edges();
      int cnts[6] = '{0, 20, 1, 1, 1, 2};
      int k = 0;
      bit acc;
      out_ready = 1'b1;
      req_mode = 1'b1;
      req_valid = 1'b1;
      for (int c = 0; c < 100 && k < 6; c++) begin
         req_count = cnts[k];
         req_index = $urandom_range(0, 9);
         #1;
         vectors++;
         if (dut_view() !== model_view()) begin
            miscompares++;
            $display("FAIL count_edges: dut %h model %h", dut_view(), model_view());
         end
         acc = m_ready();
         advance();
         rand_data();
         if (acc) k++;
      end
      req_valid = 1'b0;
      for (int c = 0; c < 16 && q.size() > 0; c++) begin
         #1;
         vectors++;
         if (dut_view() !== model_view()) begin
            miscompares++;
            $display("FAIL count_edges_drain: dut %h model %h", dut_view(), model_view());
         end
         advance();
      end
   endtask

   task automatic test_backpressure();
      bit acc;
      rand_data();
      req_valid = 1'b1;
      req_mode = 1'b1;
      req_index = 0;
      req_count = 8;
      out_ready = 1'b0;
      for (int c = 0; c < 200 && (req_valid || q.size() > 0); c++) begin
         #1;
         vectors++;
         if (dut_view() !== model_view()) begin
            miscompares++;
            $display("FAIL backpressure: dut %h model %h", dut_view(), model_view());
         end
         acc = req_valid && m_ready();
         advance();
         if (acc) req_valid = 1'b0;
         out_ready = $urandom_range(0, 1);
         rand_data();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         req_valid = $urandom_range(0, 1);
         req_mode = $urandom_range(0, 1);
         req_index = $urandom_range(0, 11);
         req_count = $urandom_range(0, 10);
         out_ready = $urandom_range(0, 3) != 0;
         rand_data();
         #1;
         vectors++;
         if (dut_view() !== model_view()) begin
            miscompares++;
            $display("FAIL random: dut %h model %h", dut_view(), model_view());
         end
         advance();
      end
      req_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 16 && q.size() > 0; c++) begin
         #1;
         vectors++;
         if (dut_view() !== model_view()) begin
            miscompares++;
            $display("FAIL random_drain: dut %h model %h", dut_view(), model_view());
         end
         advance();
      end
   endtask

   task automatic test_mid_reset();
      rand_data();
      out_ready = 1'b1;
      req_valid = 1'b1;
      req_mode = 1'b1;
      req_index = 2;
      req_count = 6;
      #1;
      advance();
      req_valid = 1'b0;
      repeat (3) advance();
      reset = 1'b1;
      q.delete();
      multi = 1'b0;
      #1;
      vectors++;
      if ({out_valid, busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL mid_reset: valid/busy %b required 00", {out_valid, busy});
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      rand_data();
      req_valid = 1'b1;
      req_mode = 1'b0;
      req_index = 5;
      #1;
      vectors++;
      if (dut_view() !== model_view()) begin
         miscompares++;
         $display("FAIL post_reset_idle: dut %h model %h", dut_view(), model_view());
      end
      advance();
      req_valid = 1'b0;
      #1;
      vectors++;
      if (!(out_valid === 1'b1 && out_lane === 3'd5) || dut_view() !== model_view()) begin
         miscompares++;
         $display("FAIL post_reset_lane5: dut %h model %h", dut_view(), model_view());
      end
      advance();
   endtask

   task automatic test_mode_ignored();
      rand_data();
      out_ready = 1'b1;
      req_valid = 1'b1;
      req_mode = 1'b1;
      req_index = 3;
      req_count = 5;
      #1;
      advance();
      req_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         vectors++;
         if (dut_view() !== model_view()) begin
            miscompares++;
            $display("FAIL mode_ignored: dut %h model %h", dut_view(), model_view());
         end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream_wrap();
      test_count_edges();
      test_backpressure();
      test_random();
      test_mid_reset();
      test_mode_ignored();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
